// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types: receive/transmit frame format, baud
//               generator configuration, receiver state encoding and small
//               helpers that sanitise the frame format fields.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame format. data_len counts data bits (5..8), stop_len counts stop
  // bits (1..2). parity_even=1 selects even parity, 0 selects odd parity.
  typedef struct packed {
    logic       parity_en;
    logic       parity_even;
    logic [3:0] data_len;
    logic [1:0] stop_len;
  } uart_config;

  // Baud generator configuration: clk cycles per oversample tick and the
  // per-direction enables.
  typedef struct packed {
    logic [15:0] baud_div;
    logic        rx_en;
    logic        tx_en;
  } uart_config_bdgen;

  // Receiver state encoding.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Oversample tick positions inside one bit (16 ticks per bit).
  localparam logic [3:0] c_tick_mid  = 4'd7;
  localparam logic [3:0] c_tick_last = 4'd15;

  // Out-of-range data lengths are forced into 5..8 so the bit counter and
  // the output alignment can never run past the 8-bit shift register.
  function automatic logic [3:0] clamp_data_len(input logic [3:0] len);
    if (len < 4'd5) begin
      return 4'd5;
    end else if (len > 4'd8) begin
      return 4'd8;
    end else begin
      return len;
    end
  endfunction

  // 0 is treated as one stop bit, 3 as two stop bits.
  function automatic logic [1:0] clamp_stop_len(input logic [1:0] len);
    if (len == 2'd0) begin
      return 2'd1;
    end else if (len == 2'd3) begin
      return 2'd2;
    end else begin
      return len;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input bit.
//               Both flops reset to RESET_VAL.
// Ports       : clk  - destination clock
//               rstn - asynchronous active-low reset
//               d    - asynchronous input
//               q    - synchronized output (two clk of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver with 16x oversampling. Detects a start bit on
//               a falling edge of the synchronized line, confirms it at
//               mid-bit, then samples data, optional parity and stop bits at
//               the centre of each bit. Results are published with a
//               one-clk rx_done pulse and held until the next frame.
// Ports       : clk        - system clock
//               rstn       - asynchronous active-low reset
//               ucfg       - frame format, captured at start detection
//               pls_rx     - one-clk oversample tick (16 per bit)
//               uart_rxd   - asynchronous serial line, idle high
//               en_rxcnt   - enables the baud generator rx tick counter
//               data       - last received word, LSB-aligned, zero-extended
//               rx_done    - one-clk pulse per completed frame
//               parity_err - parity mismatch of the last frame
//               frame_err  - a stop bit of the last frame was low
//               rx_busy    - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  uart_config ucfg,
  input  logic       pls_rx,
  input  logic       uart_rxd,
  output logic       en_rxcnt,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  // --------------------------------------------------------------------------
  // Line synchronization and edge detection
  // --------------------------------------------------------------------------
  logic w_rxd;
  logic r_rxd_prev;
  logic w_fall;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rxd (
    .clk  (clk),
    .rstn (rstn),
    .d    (uart_rxd),
    .q    (w_rxd)
  );

  // Only a genuine high-to-low transition starts a frame. A frame that ended
  // on a low stop bit therefore cannot restart until the line has gone high.
  assign w_fall = r_rxd_prev & ~w_rxd;

  // --------------------------------------------------------------------------
  // Frame state
  // --------------------------------------------------------------------------
  rx_state_e  r_state;
  rx_state_e  w_state_nxt;

  logic [3:0] r_tick;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;
  logic [7:0] r_shift;
  logic       r_par_acc;
  logic       r_par_err;
  logic       r_frm_err;
  uart_config r_cfg;

  // Control strobes from the next-state logic
  logic       w_start;
  logic       w_tick_clr;
  logic       w_shift_en;
  logic       w_par_chk;
  logic       w_stop_smp;
  logic       w_deliver;

  logic       w_at_mid;
  logic       w_at_last;
  logic       w_last_data;
  logic       w_last_stop;
  logic [7:0] w_data_aligned;

  assign rx_busy  = (r_state != RX_IDLE);
  assign en_rxcnt = rx_busy;

  assign w_at_mid    = pls_rx & (r_tick == c_tick_mid);
  assign w_at_last   = pls_rx & (r_tick == c_tick_last);
  assign w_last_data = ({1'b0, r_bit_cnt} == (r_cfg.data_len - 4'd1));
  assign w_last_stop = ({1'b0, r_stop_cnt} == (r_cfg.stop_len - 2'd1));

  // Data bits enter at the MSB and move right, so after data_len bits the
  // word sits in the top data_len positions; shifting it down aligns it to
  // bit 0 and fills the unused upper bits with zeros.
  assign w_data_aligned = r_shift >> (4'd8 - r_cfg.data_len);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_tick_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_smp  = 1'b0;
    w_deliver   = 1'b0;

    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_start     = 1'b1;
          w_state_nxt = RX_START;
        end
      end

      // Re-check the line at the middle of the start bit so that short low
      // glitches are rejected.
      RX_START: begin
        if (w_at_mid) begin
          if (w_rxd) begin
            w_state_nxt = RX_IDLE;
          end else begin
            w_tick_clr  = 1'b1;
            w_state_nxt = RX_DATA;
          end
        end
      end

      RX_DATA: begin
        if (w_at_last) begin
          w_shift_en = 1'b1;
          if (w_last_data) begin
            if (r_cfg.parity_en) begin
              w_state_nxt = RX_PARITY;
            end else begin
              w_state_nxt = RX_STOP;
            end
          end
        end
      end

      RX_PARITY: begin
        if (w_at_last) begin
          w_par_chk   = 1'b1;
          w_state_nxt = RX_STOP;
        end
      end

      RX_STOP: begin
        if (w_at_last) begin
          w_stop_smp = 1'b1;
          if (w_last_stop) begin
            w_deliver   = 1'b1;
            w_state_nxt = RX_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, shift register, error accumulation, outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rxd_prev <= 1'b1;
      r_tick     <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_shift    <= 8'd0;
      r_par_acc  <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_cfg      <= '0;
      data       <= 8'd0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_rxd_prev <= w_rxd;

      // The tick counter only advances on oversample pulses and wraps
      // 15 -> 0 naturally, which spaces consecutive samples 16 ticks apart.
      if (w_start || w_tick_clr) begin
        r_tick <= 4'd0;
      end else if (rx_busy && pls_rx) begin
        r_tick <= r_tick + 4'd1;
      end

      if (w_start) begin
        r_cfg.parity_en   <= ucfg.parity_en;
        r_cfg.parity_even <= ucfg.parity_even;
        r_cfg.data_len    <= clamp_data_len(ucfg.data_len);
        r_cfg.stop_len    <= clamp_stop_len(ucfg.stop_len);
        r_bit_cnt         <= 3'd0;
        r_stop_cnt        <= 1'b0;
        r_shift           <= 8'd0;
        r_par_acc         <= 1'b0;
        r_par_err         <= 1'b0;
        r_frm_err         <= 1'b0;
      end else begin
        if (w_shift_en) begin
          r_shift   <= {w_rxd, r_shift[7:1]};
          r_par_acc <= r_par_acc ^ w_rxd;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end

        // Even parity expects the XOR of the data bits; odd parity expects
        // its complement.
        if (w_par_chk) begin
          r_par_err <= (w_rxd != (r_par_acc ^ ~r_cfg.parity_even));
        end

        if (w_stop_smp) begin
          r_stop_cnt <= r_stop_cnt + 1'b1;
          if (!w_rxd) begin
            r_frm_err <= 1'b1;
          end
        end
      end

      // The final stop sample is folded in directly so the flags are
      // complete on the same clk as rx_done.
      rx_done <= w_deliver;
      if (w_deliver) begin
        data       <= w_data_aligned;
        parity_err <= r_par_err;
        frame_err  <= r_frm_err | ~w_rxd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A behavioural transmitter
//               drives the serial line; a frame-level model predicts each
//               received word and its error flags, and a monitor checks
//               every rx_done against the predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk;
  logic       rstn;
  uart_config ucfg;
  logic       pls_rx;
  logic       uart_rxd;
  logic       en_rxcnt;
  logic [7:0] data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         tick_cnt = 0;
  logic [7:0] last_data = 8'd0;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  logic       prev_done = 1'b0;

  uart_rx u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .ucfg       (ucfg),
    .pls_rx     (pls_rx),
    .uart_rxd   (uart_rxd),
    .en_rxcnt   (en_rxcnt),
    .data       (data),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversample tick: one clk high out of every four.
  initial begin
    pls_rx = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      pls_rx = 1'b1;
      @(negedge clk);
      pls_rx = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (pls_rx) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    while (tick_cnt < target) @(negedge clk);
  endtask

  // Drive one frame (16 ticks per bit) and queue its predicted result.
  // abort_bit >= 0 stops mid-way through that data bit and queues nothing.
  task automatic send_frame(input logic [7:0] word, input uart_config cfg,
                            input logic flip_par, input logic [1:0] stop_bits,
                            input int abort_bit, input logic scramble);
    int         len;
    int         sl;
    logic       par;
    logic [7:0] mask;
    logic [7:0] rnd;
    exp_t       e;
    len    = int'(cfg.data_len);
    sl     = int'(cfg.stop_len);
    mask   = 8'((16'd1 << len) - 16'd1);
    par    = ^(word & mask);
    if (!cfg.parity_even) par = ~par;
    if (flip_par) par = ~par;
    e.data = word & mask;
    e.perr = cfg.parity_en & flip_par;
    e.ferr = (stop_bits[0] == 1'b0) || (sl == 2 && stop_bits[1] == 1'b0);
    if (abort_bit < 0) exp_q.push_back(e);

    ucfg = cfg;
    @(negedge clk);
    uart_rxd = 1'b0;
    wait_ticks(16);
    if (scramble) begin
      rnd  = 8'($urandom);
      ucfg = rnd;
    end
    for (int i = 0; i < len; i++) begin
      uart_rxd = word[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        return;
      end
      wait_ticks(16);
    end
    if (cfg.parity_en) begin
      uart_rxd = par;
      wait_ticks(16);
    end
    for (int s = 0; s < sl; s++) begin
      uart_rxd = stop_bits[s];
      wait_ticks(16);
    end
    uart_rxd = 1'b1;
  endtask

  // Monitor: every rx_done must match the oldest prediction; between pulses
  // the published results must hold their last predicted values.
  always @(negedge clk) begin
    if (!rstn) begin
      last_data = 8'd0;
      last_perr = 1'b0;
      last_ferr = 1'b0;
      prev_done = 1'b0;
    end else begin
      chk("en_rxcnt_vs_busy", 32'(en_rxcnt), 32'(rx_busy));
      if (rx_done) begin
        done_cnt++;
        chk("busy_at_done", 32'(rx_busy), 32'(0));
        chk("done_single_clk", 32'(prev_done), 32'(0));
        chk("done_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("rx_data", 32'(data), 32'(mon_e.data));
          chk("rx_parity_err", 32'(parity_err), 32'(mon_e.perr));
          chk("rx_frame_err", 32'(frame_err), 32'(mon_e.ferr));
          last_data = mon_e.data;
          last_perr = mon_e.perr;
          last_ferr = mon_e.ferr;
        end
      end else begin
        chk("data_hold", 32'(data), 32'(last_data));
        chk("parity_err_hold", 32'(parity_err), 32'(last_perr));
        chk("frame_err_hold", 32'(frame_err), 32'(last_ferr));
      end
      prev_done = rx_done;
    end
  end

  initial begin
    uart_config cfg;
    logic [7:0] word;
    logic       flip;
    logic [1:0] stops;
    int         gap;
    int         d0;

    rstn     = 1'b0;
    uart_rxd = 1'b1;
    ucfg     = '0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    // Reset state
    chk("reset_data", 32'(data), 32'(0));
    chk("reset_parity_err", 32'(parity_err), 32'(0));
    chk("reset_frame_err", 32'(frame_err), 32'(0));
    chk("reset_rx_done", 32'(rx_done), 32'(0));
    chk("reset_rx_busy", 32'(rx_busy), 32'(0));
    chk("reset_en_rxcnt", 32'(en_rxcnt), 32'(0));
    wait_ticks(4);

    // 8 data bits, even parity, 2 stop bits, clean frame
    cfg = '{1'b1, 1'b1, 4'd8, 2'd2};
    d0  = done_cnt;
    send_frame(8'h0F, cfg, 1'b0, 2'b11, -1, 1'b1);
    wait_ticks(2);
    chk("8e2_done_count", 32'(done_cnt - d0), 32'(1));
    chk("8e2_data", 32'(data), 32'h0F);
    chk("8e2_parity_err", 32'(parity_err), 32'(0));
    chk("8e2_frame_err", 32'(frame_err), 32'(0));

    // Same format, corrupted parity bit
    d0 = done_cnt;
    send_frame(8'h0F, cfg, 1'b1, 2'b11, -1, 1'b1);
    wait_ticks(2);
    chk("badpar_done_count", 32'(done_cnt - d0), 32'(1));
    chk("badpar_data", 32'(data), 32'h0F);
    chk("badpar_parity_err", 32'(parity_err), 32'(1));
    chk("badpar_frame_err", 32'(frame_err), 32'(0));

    // Second stop bit low, line then held low: no restart until it goes high
    d0 = done_cnt;
    send_frame(8'h0F, cfg, 1'b0, 2'b01, -1, 1'b1);
    uart_rxd = 1'b0;
    wait_ticks(48);
    chk("lowstop_done_count", 32'(done_cnt - d0), 32'(1));
    chk("lowstop_frame_err", 32'(frame_err), 32'(1));
    chk("lowstop_parity_err", 32'(parity_err), 32'(0));
    chk("lowstop_idle_while_low", 32'(rx_busy), 32'(0));
    uart_rxd = 1'b1;
    wait_ticks(4);
    chk("lowstop_no_extra_done", 32'(done_cnt - d0), 32'(1));

    // Short low glitch in IDLE: false start
    d0 = done_cnt;
    uart_rxd = 1'b0;
    wait_ticks(2);
    chk("glitch_start_seen", 32'(rx_busy), 32'(1));
    wait_ticks(2);
    uart_rxd = 1'b1;
    wait_ticks(16);
    chk("glitch_back_idle", 32'(rx_busy), 32'(0));
    chk("glitch_en_rxcnt", 32'(en_rxcnt), 32'(0));
    chk("glitch_no_done", 32'(done_cnt - d0), 32'(0));

    // 5 data bits, no parity, 1 stop bit, back-to-back frames
    cfg = '{1'b0, 1'b0, 4'd5, 2'd1};
    d0  = done_cnt;
    send_frame(8'h15, cfg, 1'b0, 2'b11, -1, 1'b1);
    send_frame(8'h0A, cfg, 1'b0, 2'b11, -1, 1'b1);
    wait_ticks(2);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'(2));
    chk("b2b_last_data", 32'(data), 32'h0A);
    chk("b2b_queue_drained", 32'(exp_q.size()), 32'(0));

    // Reset during data bit 3, then a full frame
    cfg = '{1'b0, 1'b1, 4'd8, 2'd1};
    d0  = done_cnt;
    send_frame(8'hA5, cfg, 1'b0, 2'b11, 3, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_data", 32'(data), 32'(0));
    chk("midrst_parity_err", 32'(parity_err), 32'(0));
    chk("midrst_frame_err", 32'(frame_err), 32'(0));
    chk("midrst_rx_done", 32'(rx_done), 32'(0));
    chk("midrst_rx_busy", 32'(rx_busy), 32'(0));
    chk("midrst_en_rxcnt", 32'(en_rxcnt), 32'(0));
    uart_rxd = 1'b1;
    repeat (6) @(posedge clk);
    #2 rstn = 1'b1;
    wait_ticks(4);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'(0));
    send_frame(8'hA5, cfg, 1'b0, 2'b11, -1, 1'b1);
    wait_ticks(2);
    chk("after_rst_done_count", 32'(done_cnt - d0), 32'(1));
    chk("after_rst_data", 32'(data), 32'hA5);

    // Randomized formats, words, parity corruption and stop-bit faults
    for (int n = 0; n < 30; n++) begin
      cfg.parity_en   = 1'($urandom_range(0, 1));
      cfg.parity_even = 1'($urandom_range(0, 1));
      cfg.data_len    = 4'($urandom_range(5, 8));
      cfg.stop_len    = 2'($urandom_range(1, 2));
      word            = 8'($urandom);
      flip            = cfg.parity_en && ($urandom_range(0, 3) == 0);
      stops           = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send_frame(word, cfg, flip, stops, -1, 1'b1);
      gap = int'($urandom_range(0, 6));
      if (gap == 0 && stops != 2'b11) gap = 1;
      wait_ticks(gap);
    end

    wait_ticks(4);
    chk("final_queue_drained", 32'(exp_q.size()), 32'(0));
    chk("final_idle", 32'(rx_busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
